// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and default sizes for the UART transmit FIFO
package uart_pkg;

   localparam int UART_FIFO_DEPTH_DEF = 16;
   localparam int UART_DATA_W         = 8;

   typedef enum logic [1:0] {
      F_IDLE,
      F_START,
      F_WAIT_LOW,
      F_WAIT_HIGH
   } FIFO_STATES;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - circular byte store with registered occupancy, full and empty
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO pacing bytes into a UART via a tx_ready handshake
// Define UART_TX_FIFO_OVF_EN to enable the sticky overflow flag and its ovf_clr input.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_FIFO_DEPTH_DEF,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   wr_en,
   input  logic                   tx_ready,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_start,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   input  logic                   ovf_clr,
   output logic                   overflow
);

   FIFO_STATES        state_q, state_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [DATA_W-1:0] rd_data;
   logic              fifo_full, fifo_empty;
   logic              pop, push;

   assign pop  = (state_q == F_IDLE) && !fifo_empty && tx_ready;
   // A same-edge pop frees a slot, so a full FIFO may still accept the write.
   assign push = wr_en && (!fifo_full || pop);

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (wr_data),
      .pop     (pop),
      .rd_data (rd_data),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      case (state_q)
         F_IDLE: begin
            if (pop) begin
               state_d   = F_START;
               tx_data_d = rd_data;
            end
         end
         F_START:     state_d = F_WAIT_LOW;
         F_WAIT_LOW:  if (!tx_ready) state_d = F_WAIT_HIGH;
         F_WAIT_HIGH: if (tx_ready)  state_d = F_IDLE;
         default:     state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= F_IDLE;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_start = (state_q == F_START);
   assign tx_data  = tx_data_q;
   assign full     = fifo_full;
   assign empty    = fifo_empty;

`ifdef UART_TX_FIFO_OVF_EN
   logic overflow_q, overflow_d;

   // Clear wins over a drop landing on the same edge.
   always_comb begin
      overflow_d = overflow_q;
      if (ovf_clr)
         overflow_d = 1'b0;
      else if (wr_en && !push)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench with a queue-based reference model for uart_tx_fifo
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       tx_ready = 1'b1;
   logic       ovf_clr = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;

   uart_tx_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .ovf_clr  (ovf_clr),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queue plus the transmitter handshake expectations.
   logic [7:0] mq[$];
   bit         m_start, m_need_low, m_need_high, m_ovf;
   logic [7:0] m_data;
   bit         m_idle, m_pop, m_push, m_drop;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_start = 0; m_need_low = 0; m_need_high = 0;
         m_data = 8'h00; m_ovf = 0;
      end else begin
         m_idle = !(m_start || m_need_low || m_need_high);
         m_pop  = m_idle && (mq.size() != 0) && tx_ready;
         m_push = wr_en && ((mq.size() < DEPTH) || m_pop);
         m_drop = wr_en && !m_push;
         if (m_start) begin
            m_start = 0; m_need_low = 1;
         end else if (m_need_low) begin
            if (!tx_ready) begin m_need_low = 0; m_need_high = 1; end
         end else if (m_need_high) begin
            if (tx_ready) m_need_high = 0;
         end
         if (m_pop) begin
            m_data  = mq.pop_front();
            m_start = 1;
         end
         if (m_push) mq.push_back(wr_data);
`ifdef UART_TX_FIFO_OVF_EN
         if (ovf_clr) m_ovf = 0;
         else if (m_drop) m_ovf = 1;
`endif
      end
   end

   logic [7:0] sent[$];
   int         pulses = 0;
   int         peak = 0;

   always @(negedge clk) begin
      cmp("tx_start", 32'(tx_start), 32'(m_start));
      cmp("tx_data",  32'(tx_data),  32'(m_data));
      cmp("count",    32'(count),    32'(mq.size()));
      cmp("full",     32'(full),     32'(mq.size() == DEPTH));
      cmp("empty",    32'(empty),    32'(mq.size() == 0));
      cmp("overflow", 32'(overflow), 32'(m_ovf));
      if (tx_start && !rst) begin
         sent.push_back(tx_data);
         pulses++;
      end
      if (int'(count) > peak) peak = int'(count);
   end

   // Transmitter emulation: tx_ready drops for 11 cycles after each start.
   int busy = 0;
   bit hold_low = 0;
   bit no_resp = 0;

   task automatic step(input logic we, input logic [7:0] wd, input logic clr);
      @(negedge clk);
      #1;
      if (tx_start && !no_resp) busy = 11;
      else if (busy > 0) busy--;
      tx_ready = !hold_low && (busy == 0);
      wr_en    = we;
      wr_data  = wd;
      ovf_clr  = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   logic [7:0] exp_bytes[$];

   initial begin
      rst = 1'b1;
      idle(3);
      cmp("rst_count", 32'(count), 32'd0);
      cmp("rst_empty", 32'(empty), 32'd1);
      cmp("rst_full", 32'(full), 32'd0);
      cmp("rst_tx_data", 32'(tx_data), 32'h00);
      @(negedge clk); #1 rst = 1'b0;

      // Single byte and its two-edge latency
      idle(2);
      sent.delete();
      step(1'b1, 8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      cmp("lat_no_start_yet", 32'(tx_start), 32'd0);
      step(1'b0, 8'h00, 1'b0);
      cmp("lat_start", 32'(tx_start), 32'd1);
      cmp("lat_data", 32'(tx_data), 32'hA5);
      idle(30);
      cmp("single_empty", 32'(empty), 32'd1);
      cmp("single_pulses", 32'(sent.size()), 32'd1);

      // Burst of five with the transmitter pacing
      sent.delete();
      peak = 0;
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
      idle(120);
      cmp("burst_pulses", 32'(sent.size()), 32'd5);
      for (int i = 0; i < 5 && i < sent.size(); i++) cmp("burst_order", 32'(sent[i]), 32'(i + 1));
      cmp("burst_peak_ok", 32'(peak == 4 || peak == 5), 32'd1);

      // Fill past full with the transmitter held busy
      hold_low = 1;
      idle(2);
      for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      cmp("fill_full", 32'(full), 32'd1);
      cmp("fill_count", 32'(count), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
      cmp("ovf_set", 32'(overflow), 32'd1);
`else
      cmp("ovf_tied", 32'(overflow), 32'd0);
`endif
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      cmp("ovf_cleared", 32'(overflow), 32'd0);
      sent.delete();
      hold_low = 0;
      idle(300);
      cmp("fill_drained", 32'(sent.size()), 32'd16);
      for (int i = 0; i < 16 && i < sent.size(); i++) cmp("fill_order", 32'(sent[i]), 32'(8'h10 + i));

      // Interleaved traffic across several pointer wraps
      sent.delete();
      exp_bytes.delete();
      for (int i = 0; i < 40; i++) begin
         exp_bytes.push_back(8'((i * 37 + 5) & 8'hFF));
         step(1'b1, exp_bytes[i], 1'b0);
         idle(15);
      end
      idle(60);
      cmp("wrap_len", 32'(sent.size()), 32'd40);
      for (int i = 0; i < 40 && i < sent.size(); i++) cmp("wrap_data", 32'(sent[i]), 32'(exp_bytes[i]));
      cmp("wrap_count", 32'(count), 32'd0);

      // Reset while waiting for tx_ready to fall, three bytes still queued
      no_resp = 1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
      @(negedge clk); #1;
      wr_en = 1'b0;
      cmp("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      cmp("mid_rst_count", 32'(count), 32'd0);
      cmp("mid_rst_empty", 32'(empty), 32'd1);
      cmp("mid_rst_start", 32'(tx_start), 32'd0);
      cmp("mid_rst_data", 32'(tx_data), 32'h00);
      #1 rst = 1'b0;
      no_resp = 0;
      pulses = 0;
      idle(30);
      cmp("post_rst_pulses", 32'(pulses), 32'd0);

      // Push and pop on the same edge while full
      hold_low = 1;
      idle(2);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      sent.delete();
      hold_low = 0;
      step(1'b1, 8'h50, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      cmp("pp_count", 32'(count), 32'd16);
      cmp("pp_full", 32'(full), 32'd1);
      idle(300);
      cmp("pp_len", 32'(sent.size()), 32'd17);
      for (int i = 0; i < 17 && i < sent.size(); i++) cmp("pp_order", 32'(sent[i]), 32'(8'h40 + i));
      cmp("pp_ovf", 32'(overflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
